ras_circ: RTL and testbench

Parametrised, clocked return-address stack for the fetch-stage branch predictor. It replaces the single-width combinational stack with a circular buffer of configurable depth and address width. The buffer overwrites the oldest entry on overflow and supports simultaneous push/pop as "replace top". Checkpoint/restore ports let the pipeline rewind the stack pointer after a mispredicted call or return. It sits beside the BTB: fetch drives push/pop on predicted calls and returns, and the execute stage drives restore on redirect.

---
 rtl/ras_circ.sv | 104 ++++++++++
 tb/tb_ras_circ.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ras_circ.sv
`default_nettype none
// =============================================================================
// ras_circ - circular return-address stack with overwrite-on-overflow and
//            pointer/occupancy checkpoint restore.               Rev 1.0
// =============================================================================
module ras_circ #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [XLEN-1:0]  push_addr,
   input  logic             restore,
   input  logic [PTR_W-1:0] restore_tos,
   input  logic [PTR_W:0]   restore_cnt,
   output logic [XLEN-1:0]  top_addr,
   output logic             top_valid,
   output logic [PTR_W-1:0] ckpt_tos,
   output logic [PTR_W:0]   ckpt_cnt,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [PTR_W:0] C_FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0] tos_q, tos_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             nonempty;
   logic [PTR_W-1:0] tos_m1;
   logic             wr_en;
   logic [PTR_W-1:0] wr_idx;

   assign nonempty = (cnt_q != '0);
   assign tos_m1   = tos_q - PTR_W'(1);

   always_comb begin
      tos_d       = tos_q;
      cnt_d       = cnt_q;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = tos_q;
      if (restore) begin
         tos_d = restore_tos;
         cnt_d = (restore_cnt > C_FULL_CNT) ? C_FULL_CNT : restore_cnt;
      end else if (push && pop && nonempty) begin
         wr_en  = 1'b1;
         wr_idx = tos_m1;
      end else if (push) begin
         // An empty-stack push+pop falls through here as a plain push.
         wr_en = 1'b1;
         tos_d = tos_q + PTR_W'(1);
         if (cnt_q < C_FULL_CNT) begin
            cnt_d = cnt_q + (PTR_W+1)'(1);
         end else begin
            overflow_d = 1'b1;
         end
      end else if (pop) begin
         if (nonempty) begin
            tos_d = tos_m1;
            cnt_d = cnt_q - (PTR_W+1)'(1);
         end else begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tos_q       <= '0;
         cnt_q       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         tos_q       <= tos_d;
         cnt_q       <= cnt_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset; only the pointers matter.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) begin
         mem_q[wr_idx] <= push_addr;
      end
   end

   assign top_addr  = nonempty ? mem_q[tos_m1] : '0;
   assign top_valid = nonempty;
   assign ckpt_tos  = tos_q;
   assign ckpt_cnt  = cnt_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ras_circ.sv
`default_nettype none
// =============================================================================
// tb_ras_circ - scoreboard bench for ras_circ at DEPTH=4, XLEN=32.  Rev 1.0
// =============================================================================
module tb_ras_circ;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int PTR_W = 2;

   logic             clk = 1'b0;
   logic             reset, push, pop, restore;
   logic [XLEN-1:0]  push_addr;
   logic [PTR_W-1:0] restore_tos;
   logic [PTR_W:0]   restore_cnt;
   logic [XLEN-1:0]  top_addr;
   logic             top_valid;
   logic [PTR_W-1:0] ckpt_tos;
   logic [PTR_W:0]   ckpt_cnt;
   logic             overflow, underflow;

   ras_circ #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .push_addr(push_addr),
      .restore(restore), .restore_tos(restore_tos), .restore_cnt(restore_cnt),
      .top_addr(top_addr), .top_valid(top_valid), .ckpt_tos(ckpt_tos),
      .ckpt_cnt(ckpt_cnt), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] top;
      logic        vld;
      int          tos;
      int          cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_mem [DEPTH];
   int          m_tos, m_cnt;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, advance the reference model, queue its expectation,
   // then compare after the edge.
   task automatic step(input bit rst, input bit rs, input bit ps, input bit pp,
                       input logic [31:0] a, input int rtos, input int rcnt);
      exp_t e;
      exp_t g;
      reset = rst; restore = rs; push = ps; pop = pp; push_addr = a;
      restore_tos = PTR_W'(rtos); restore_cnt = (PTR_W+1)'(rcnt);
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (rst) begin
         m_tos = 0; m_cnt = 0;
      end else if (rs) begin
         m_tos = rtos;
         m_cnt = (rcnt > DEPTH) ? DEPTH : rcnt;
      end else if (ps && pp && m_cnt > 0) begin
         m_mem[(m_tos + DEPTH - 1) % DEPTH] = a;
      end else if (ps) begin
         m_mem[m_tos] = a;
         m_tos = (m_tos + 1) % DEPTH;
         if (m_cnt < DEPTH) m_cnt++;
         else e.ovf = 1'b1;
      end else if (pp) begin
         if (m_cnt > 0) begin
            m_tos = (m_tos + DEPTH - 1) % DEPTH;
            m_cnt--;
         end else begin
            e.unf = 1'b1;
         end
      end
      e.tos = m_tos;
      e.cnt = m_cnt;
      e.vld = (m_cnt != 0);
      e.top = (m_cnt != 0) ? m_mem[(m_tos + DEPTH - 1) % DEPTH] : 32'h0;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      g = sb_q.pop_front();
      chk("top_addr",  64'(top_addr),  64'(g.top));
      chk("top_valid", 64'(top_valid), 64'(g.vld));
      chk("ckpt_tos",  64'(ckpt_tos),  64'(g.tos));
      chk("ckpt_cnt",  64'(ckpt_cnt),  64'(g.cnt));
      chk("overflow",  64'(overflow),  64'(g.ovf));
      chk("underflow", 64'(underflow), 64'(g.unf));
   endtask

   task automatic do_push(input logic [31:0] a); step(0, 0, 1, 0, a, 0, 0); endtask
   task automatic do_pop();                      step(0, 0, 0, 1, 0, 0, 0); endtask
   task automatic do_idle();                     step(0, 0, 0, 0, 0, 0, 0); endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      m_tos = 0; m_cnt = 0;
      reset = 1'b0; restore = 1'b0; push = 1'b0; pop = 1'b0;
      push_addr = '0; restore_tos = '0; restore_cnt = '0;
      #2;

      // Reset with a push pending
      step(1, 0, 1, 0, 32'h100, 0, 0);
      chk("rst_top",   64'(top_addr), 64'h0);
      chk("rst_valid", 64'(top_valid), 64'h0);
      chk("rst_cnt",   64'(ckpt_cnt), 64'h0);
      chk("rst_tos",   64'(ckpt_tos), 64'h0);

      // LIFO order
      do_push(32'h100); do_push(32'h200); do_push(32'h300);
      chk("lifo_top0", 64'(top_addr), 64'h300); do_pop();
      chk("lifo_top1", 64'(top_addr), 64'h200); do_pop();
      chk("lifo_top2", 64'(top_addr), 64'h100); do_pop();
      chk("lifo_empty", 64'(top_valid), 64'h0);
      do_idle();

      // Overflow wrap
      do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40);
      chk("pre_ovf", 64'(overflow), 64'h0);
      do_push(32'h50);
      chk("ovf_pulse", 64'(overflow), 64'h1);
      chk("ovf_cnt",   64'(ckpt_cnt), 64'h4);
      chk("ovf_tos",   64'(ckpt_tos), 64'h1);
      chk("wrap_top0", 64'(top_addr), 64'h50); do_pop();
      chk("wrap_top1", 64'(top_addr), 64'h40); do_pop();
      chk("wrap_top2", 64'(top_addr), 64'h30); do_pop();
      chk("wrap_top3", 64'(top_addr), 64'h20); do_pop();
      chk("wrap_cnt0", 64'(ckpt_cnt), 64'h0);

      // Underflow
      do_pop();
      chk("unf_pulse", 64'(underflow), 64'h1);
      chk("unf_tos",   64'(ckpt_tos), 64'h1);
      do_idle();
      chk("unf_clear", 64'(underflow), 64'h0);

      // Replace top
      do_push(32'hA0); do_push(32'hB0);
      step(0, 0, 1, 1, 32'hC0, 0, 0);
      chk("rep_top", 64'(top_addr), 64'hC0);
      chk("rep_cnt", 64'(ckpt_cnt), 64'h2);
      do_pop();
      chk("rep_pop", 64'(top_addr), 64'hA0);
      do_pop();
      step(0, 0, 1, 1, 32'hD0, 0, 0);
      chk("rep_empty_top", 64'(top_addr), 64'hD0);
      chk("rep_empty_cnt", 64'(ckpt_cnt), 64'h1);

      // Restore: the 0x900 push reuses slot 1, so the restored top is 0x900
      step(1, 0, 0, 0, 0, 0, 0);
      do_push(32'h100); do_push(32'h200);
      chk("ck_tos", 64'(ckpt_tos), 64'h2);
      chk("ck_cnt", 64'(ckpt_cnt), 64'h2);
      do_pop(); do_push(32'h900); do_pop();
      step(0, 1, 1, 0, 32'h777, 2, 2);
      chk("rs_tos", 64'(ckpt_tos), 64'h2);
      chk("rs_cnt", 64'(ckpt_cnt), 64'h2);
      chk("rs_top", 64'(top_addr), 64'h900);
      step(0, 1, 0, 1, 0, 2, 7);
      chk("rs_sat_cnt", 64'(ckpt_cnt), 64'h4);
      do_pop(); do_pop();
      chk("rs_deep_top", 64'(top_addr), 64'h0_FFFF_FFFF & 64'(m_mem[(m_tos + DEPTH - 1) % DEPTH]));

      // Reset mid-operation with pop asserted
      step(1, 0, 0, 1, 0, 0, 0);
      chk("mid_rst_cnt", 64'(ckpt_cnt), 64'h0);
      do_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
